// File: rtl/add_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encodings
// and the parameter legality rule used at elaboration.
package add_pipe_pkg;

    // Operation select values on the sub input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // WIDTH must split evenly into STAGES non-empty chunks.
    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/add_pipe_chunk.sv
// One CHUNK-bit slice of the carry chain. The operand MSBs are exposed as
// taps so the final stage can form signed overflow without re-deriving them.
module add_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          a_msb,
    output logic          b_msb
);

    // Ripple add of the slice, carry-out taken from the extra top bit.
    always_comb begin
        {co, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};
    end

    assign a_msb = a[CW-1];
    assign b_msb = b[CW-1];

endmodule

// File: rtl/add_pipe.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake.
//
// Handshake: a beat moves on in_valid && in_ready and a result is consumed on
// out_valid && out_ready. in_ready = !(out_valid && !out_ready); whenever the
// output is stalled, every stage holds, so nothing is lost or duplicated and
// sum/cout/ovf stay frozen until consumed.
//
// Stage k adds chunk k of a and b_eff using the carry registered by stage k-1.
// Each stage register carries the not-yet-added upper operand bits forward
// (skew) and the already-finished lower sum bits (deskew), so the last stage
// holds the complete result.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("add_pipe: WIDTH must be a positive multiple of STAGES");
    end

    logic             stall;
    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

    // Subtraction is a + ~b + 1; the caller's cin is ignored in that mode.
    assign b_eff = (sub == OP_SUB) ? ~b : b;
    assign cin0  = (sub == OP_SUB) ? 1'b1 : cin;

    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Sum bits that are final once this stage has captured its chunk.
        localparam int DONE = (k + 1) * CHUNK;

        logic [CHUNK-1:0] ca;
        logic [CHUNK-1:0] cb;
        logic [CHUNK-1:0] cs;
        logic             ci;
        logic             co;
        logic             a_msb;
        logic             b_msb;
        logic             v_in;
        logic [DONE-1:0]  s_next;

        logic             v_q;
        logic             c_q;
        logic [DONE-1:0]  s_q;

        add_chunk #(.CW(CHUNK)) u_chunk (
            .a     (ca),
            .b     (cb),
            .ci    (ci),
            .s     (cs),
            .co    (co),
            .a_msb (a_msb),
            .b_msb (b_msb)
        );

        if (k == 0) begin : g_src
            assign ca     = a[CHUNK-1:0];
            assign cb     = b_eff[CHUNK-1:0];
            assign ci     = cin0;
            assign v_in   = in_valid;
            assign s_next = cs;
        end else begin : g_src
            assign ca     = g_stage[k-1].g_carry.rem_a_q[CHUNK-1:0];
            assign cb     = g_stage[k-1].g_carry.rem_b_q[CHUNK-1:0];
            assign ci     = g_stage[k-1].c_q;
            assign v_in   = g_stage[k-1].v_q;
            assign s_next = {cs, g_stage[k-1].s_q};
        end

        // Stage register: valid bit, chunk carry and the growing sum; frozen on stall.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_in;
                c_q <= co;
                s_q <= s_next;
            end
        end

        if (k < STAGES - 1) begin : g_carry
            // Operand bits still waiting for their stage.
            localparam int RW = WIDTH - DONE;

            logic [RW-1:0] rem_a_d;
            logic [RW-1:0] rem_b_d;
            logic [RW-1:0] rem_a_q;
            logic [RW-1:0] rem_b_q;
            logic          unused_taps;

            // Only the final chunk's MSB pair matters for overflow.
            assign unused_taps = a_msb ^ b_msb;

            if (k == 0) begin : g_rem
                assign rem_a_d = a[WIDTH-1:CHUNK];
                assign rem_b_d = b_eff[WIDTH-1:CHUNK];
            end else begin : g_rem
                assign rem_a_d = g_stage[k-1].g_carry.rem_a_q[RW+CHUNK-1:CHUNK];
                assign rem_b_d = g_stage[k-1].g_carry.rem_b_q[RW+CHUNK-1:CHUNK];
            end

            // Skew registers: carry the unprocessed upper operand chunks forward.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rem_a_q <= '0;
                    rem_b_q <= '0;
                end else if (en) begin
                    rem_a_q <= rem_a_d;
                    rem_b_q <= rem_b_d;
                end
            end
        end else begin : g_last
            logic ovf_q;

            // Signed overflow: operands agree in sign but the result does not.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= (a_msb == b_msb) && (cs[CHUNK-1] != a_msb);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
